tone_sequencer: RTL and testbench

Upstream sample source for the PDM audio path: plays a fixed melody from an internal note table as a sawtooth and delivers one unsigned SAMPLE_W-bit sample per sample-rate strobe to the 1st-order delta-sigma modulator. Owns the sample-rate clock-enable divider, so the modulator consumes `sample` only when `sample_valid` is high. Silence is mid-scale, so the PDM output idles at 50 % density with no DC step between notes.

---
 rtl/tone_seq_pkg.sv | 35 +++
 rtl/ce_divider.sv | 31 +++
 rtl/tone_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_tone_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the tone sequencer: FSM states, note table layout, default melody.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package tone_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int INC_W      = 16;
    localparam int DUR_W      = 8;
    localparam int ENTRY_W    = INC_W + DUR_W;
    localparam int MELODY_CNT = 8;

    // Entry i lives at bits [i*ENTRY_W +: ENTRY_W] as {inc, dur}; the list below runs last note first.
    // Increments target C6..C7 at a 4.5 MHz strobe rate (inc = f * 65536 / 4.5e6).
    localparam logic [MELODY_CNT*ENTRY_W-1:0] MELODY = {
        16'd30, 8'd200,   // C7, held longest
        16'd29, 8'd100,   // B6
        16'd26, 8'd100,   // A6
        16'd23, 8'd100,   // G6
        16'd20, 8'd100,   // F6
        16'd19, 8'd100,   // E6
        16'd17, 8'd100,   // D6
        16'd15, 8'd100    // C6
    };

    // Mid-scale code for an unsigned sample of the given width.
    function automatic logic [15:0] mid_scale(input int w);
        mid_scale = 16'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/ce_divider.sv
// Sample-rate clock enable: counts 0..CE_DIV-1 continuously and pulses ce on the last count.
// Latency: ce is combinational from the counter register; first pulse CE_DIV-1 edges after reset release.
// Backpressure: none; free-running, shared by the sequencer and the modulator.
module ce_divider #(
    parameter int CE_DIV = 6
) (
    input  logic clk,
    input  logic rst,
    output logic ce
);

    localparam int CNT_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(CE_DIV - 1));
    assign ce     = w_last;

    // Free-running modulo-CE_DIV counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Plays the note table as a sawtooth, one unsigned sample per ce strobe; mid-scale when silent. Option macro: TONE_SEQ_ENVELOPE_EN.
// Latency: sample/sample_valid registered on the ce edge (one extra ce of lag with TONE_SEQ_ENVELOPE_EN).
// Backpressure: none; the consumer must take every strobe, which is why strobes continue in IDLE and GAP.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int CE_DIV    = 6,
    parameter int SAMPLE_W  = 13,
    parameter int BEAT_DIV  = 4500,
    parameter int GAP_BEATS = 20,
    parameter int NOTE_CNT  = 8,
    parameter logic [NOTE_CNT*ENTRY_W-1:0] NOTE_TABLE = MELODY
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        loop_en,
    output logic [SAMPLE_W-1:0]         sample,
    output logic                        sample_valid,
    output logic                        busy,
    output logic [$clog2(NOTE_CNT)-1:0] note_idx
);

    localparam int IDX_W  = $clog2(NOTE_CNT);
    localparam int BEAT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int REM_W  = 16;
    localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(mid_scale(SAMPLE_W));

    state_t             r_state;
    state_t             w_state_nx;
    logic               w_ce;
    logic [INC_W-1:0]   r_phase;
    logic [INC_W-1:0]   w_phase_nx;
    logic [BEAT_W-1:0]  r_beat;
    logic [REM_W-1:0]   r_remaining;
    logic [IDX_W-1:0]   r_note_idx;
    logic [IDX_W-1:0]   w_idx_nx;
    logic [INC_W-1:0]   w_inc;
    logic [DUR_W-1:0]   w_dur_nx;
    logic [REM_W-1:0]   w_dur_load;
    logic [SAMPLE_W-1:0] w_saw;
    logic               w_beat_tick;
    logic               w_seg_end;
    logic               w_last_note;
    logic               w_enter_play;
    logic               w_enter_gap;
    logic               w_advance;

    ce_divider #(.CE_DIV(CE_DIV)) u_ce_divider (
        .clk (clk),
        .rst (rst),
        .ce  (w_ce)
    );

    assign w_inc       = NOTE_TABLE[int'(r_note_idx)*ENTRY_W + DUR_W +: INC_W];
    assign w_dur_nx    = NOTE_TABLE[int'(w_idx_nx)*ENTRY_W +: DUR_W];
    assign w_dur_load  = (w_dur_nx == '0) ? REM_W'(1) : REM_W'(w_dur_nx);
    assign w_phase_nx  = r_phase + w_inc;
    assign w_saw       = w_phase_nx[INC_W-1 -: SAMPLE_W];
    assign w_beat_tick = (r_beat == BEAT_W'(BEAT_DIV - 1));
    assign w_seg_end   = w_ce && w_beat_tick && (r_remaining == REM_W'(1));
    assign w_last_note = (r_note_idx == IDX_W'(NOTE_CNT - 1));
    assign busy        = (r_state != IDLE);
    assign note_idx    = r_note_idx;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic; the end-of-segment decision is shared by PLAY (when GAP is skipped) and GAP.
    always_comb begin
        w_state_nx   = r_state;
        w_idx_nx     = r_note_idx;
        w_enter_play = 1'b0;
        w_enter_gap  = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nx   = PLAY;
                    w_enter_play = 1'b1;
                    w_idx_nx     = '0;
                end
            end
            PLAY: begin
                if (w_seg_end) begin
                    if (GAP_BEATS != 0) begin
                        w_state_nx  = GAP;
                        w_enter_gap = 1'b1;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            GAP: begin
                if (w_seg_end) begin
                    w_advance = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
        if (w_advance) begin
            if (!w_last_note) begin
                w_state_nx   = PLAY;
                w_enter_play = 1'b1;
                w_idx_nx     = r_note_idx + 1'b1;
            end else if (loop_en) begin
                w_state_nx   = PLAY;
                w_enter_play = 1'b1;
                w_idx_nx     = '0;
            end else begin
                w_state_nx = IDLE;
            end
        end
    end

    // Phase accumulator, beat and remaining-beat counters, current note index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= '0;
            r_beat      <= '0;
            r_remaining <= '0;
            r_note_idx  <= '0;
        end else if (w_enter_play) begin
            r_phase     <= '0;
            r_beat      <= '0;
            r_remaining <= w_dur_load;
            r_note_idx  <= w_idx_nx;
        end else if (w_enter_gap) begin
            r_beat      <= '0;
            r_remaining <= REM_W'(GAP_BEATS);
        end else if (w_ce && (r_state != IDLE)) begin
            if (r_state == PLAY) begin
                r_phase <= w_phase_nx;
            end
            if (w_beat_tick) begin
                r_beat      <= '0;
                r_remaining <= r_remaining - 1'b1;
            end else begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

`ifdef TONE_SEQ_ENVELOPE_EN
    localparam int SW9 = SAMPLE_W + 9;
    localparam int MAX = (1 << SAMPLE_W) - 1;

    logic [7:0]            r_env;
    logic [7:0]            r_env_s1;
    logic [SAMPLE_W-1:0]   r_raw;
    logic signed [SW9-1:0] w_diff;
    logic signed [SW9-1:0] w_prod;
    logic signed [SW9-1:0] w_sum;
    logic [SAMPLE_W-1:0]   w_scaled;

    // Scale the staged sawtooth around mid-scale by env/256 and clamp to the sample range.
    always_comb begin
        w_diff = $signed(SW9'(r_raw)) - $signed(SW9'(MID));
        w_prod = w_diff * $signed(SW9'(r_env_s1));
        w_sum  = $signed(SW9'(MID)) + (w_prod >>> 8);
        w_scaled = w_sum[SAMPLE_W-1:0];
        if (w_sum < 0) begin
            w_scaled = '0;
        end else if (w_sum > $signed(SW9'(MAX))) begin
            w_scaled = '1;
        end
    end

    // Envelope: full at note start, one step down per beat, stops at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_env <= '0;
        end else if (w_enter_play) begin
            r_env <= 8'd255;
        end else if (w_ce && (r_state == PLAY) && w_beat_tick && (r_env != '0)) begin
            r_env <= r_env - 1'b1;
        end
    end

    // Two-stage sample path: stage the raw saw with the envelope it belongs to, then scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raw        <= MID;
            r_env_s1     <= '0;
            sample       <= MID;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= w_ce;
            if (w_ce) begin
                r_raw    <= (r_state == PLAY) ? w_saw : MID;
                r_env_s1 <= r_env;
                sample   <= w_scaled;
            end
        end
    end
`else
    // Sample register: new sawtooth value in PLAY, mid-scale otherwise, refreshed on every strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample       <= MID;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= w_ce;
            if (w_ce) begin
                sample <= (r_state == PLAY) ? w_saw : MID;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: per-strobe vector table plus a mid-note reset sequence.
// Latency: checks are taken on the falling edge after each strobe.
// Backpressure: none; every strobe is checked.
module tb_tone_sequencer;

    localparam logic [47:0] TB_TABLE = {16'h2000, 8'd1, 16'h1000, 8'd2};

    logic        clk;
    logic        rst;
    logic        start;
    logic        loop_en;
    logic [12:0] sample;
    logic        sample_valid;
    logic        busy;
    logic [0:0]  note_idx;

    int total;
    int bad;

    typedef struct {
        logic start;
        logic loop_en;
        int   exp_sample;
        logic exp_busy;
        int   exp_idx;
    } vec_t;

    vec_t vecs[$];

    tone_sequencer #(
        .CE_DIV    (2),
        .SAMPLE_W  (13),
        .BEAT_DIV  (4),
        .GAP_BEATS (1),
        .NOTE_CNT  (2),
        .NOTE_TABLE(TB_TABLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .loop_en      (loop_en),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .note_idx     (note_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic l, input int smp, input logic b, input int idx);
        vec_t v;
        v.start      = s;
        v.loop_en    = l;
        v.exp_sample = smp;
        v.exp_busy   = b;
        v.exp_idx    = idx;
        vecs.push_back(v);
    endtask

    // Wait (bounded) for the next strobe; n = falling edges elapsed.
    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < 8);
        if (!sample_valid) begin
            check("strobe_timeout", 0, 1);
        end
    endtask

    // Gap of one beat of mid-scale strobes; the last one shows the decision's busy/idx.
    task automatic add_gap(input logic l, input int idx, input logic b_end, input int idx_end);
        for (int k = 0; k < 3; k++) add(1'b0, l, 4096, 1'b1, idx);
        add(1'b0, l, 4096, b_end, idx_end);
    endtask

    initial begin
        int n;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        start   = 1'b0;
        loop_en = 1'b0;

        #3;
        check("rst_sample", int'(sample), 4096);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_idx", int'(note_idx), 0);
        repeat (3) @(negedge clk);

        // Idle strobes.
        for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 4096, 1'b0, 0);
        // Run A: start held through note 0, no loop.
        for (int k = 1; k <= 8; k++) add(1'b1, 1'b0, 512 * k, 1'b1, 0);
        add_gap(1'b0, 0, 1'b1, 1);
        for (int k = 1; k <= 4; k++) add(1'b0, 1'b0, 1024 * k, 1'b1, 1);
        add_gap(1'b0, 1, 1'b0, 1);
        for (int k = 0; k < 2; k++) add(1'b0, 1'b0, 4096, 1'b0, 1);
        // Run B: loop enabled, wraps back to note 0 with phase restarted.
        for (int k = 1; k <= 8; k++) add(k == 1, 1'b1, 512 * k, 1'b1, 0);
        add_gap(1'b1, 0, 1'b1, 1);
        for (int k = 1; k <= 4; k++) add(1'b0, 1'b1, 1024 * k, 1'b1, 1);
        add_gap(1'b1, 1, 1'b1, 0);
        for (int k = 1; k <= 8; k++) add(1'b0, 1'b1, 512 * k, 1'b1, 0);
        add_gap(1'b1, 0, 1'b1, 1);
        for (int k = 1; k <= 2; k++) add(1'b0, 1'b1, 1024 * k, 1'b1, 1);

        rst = 1'b0;
        foreach (vecs[i]) begin
            start   = vecs[i].start;
            loop_en = vecs[i].loop_en;
            wait_strobe(n);
            check($sformatf("v%0d_period", i), n, 2);
            check($sformatf("v%0d_sample", i), int'(sample), vecs[i].exp_sample);
            check($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
            check($sformatf("v%0d_idx", i), int'(note_idx), vecs[i].exp_idx);
        end

        // Reset in the middle of note 1, with start high during reset.
        rst   = 1'b1;
        start = 1'b1;
        #1;
        check("midrst_sample", int'(sample), 4096);
        check("midrst_busy", int'(busy), 0);
        check("midrst_idx", int'(note_idx), 0);
        check("midrst_valid", int'(sample_valid), 0);
        repeat (3) @(negedge clk);
        start   = 1'b0;
        loop_en = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        check("rel_valid_1clk", int'(sample_valid), 0);
        @(negedge clk);
        check("rel_valid_2clk", int'(sample_valid), 1);
        check("rel_sample", int'(sample), 4096);
        check("rel_busy", int'(busy), 0);
        for (int k = 0; k < 3; k++) begin
            wait_strobe(n);
            check($sformatf("post_%0d_period", k), n, 2);
            check($sformatf("post_%0d_sample", k), int'(sample), 4096);
            check($sformatf("post_%0d_busy", k), int'(busy), 0);
            check($sformatf("post_%0d_idx", k), int'(note_idx), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
